// File: rtl/par2serial_tx.sv
// Parallel-to-serial transmitter: shifts 8-bit symbols MSB-first, one bit per clock.
// Sends a fixed run of COM symbols after reset, then forwards valid data or COM when idle.
module par2serial_tx #(
  parameter int unsigned SYNC_SYMS = 4,
  parameter logic [7:0]  COM       = 8'hBC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] in,
  output logic       word_req,
  output logic       out,
  output logic       active,
  output logic       com_sent
);

  localparam logic       ST_SYNC = 1'b0;
  localparam logic       ST_DATA = 1'b1;
  localparam logic [7:0] SYNC_N  = SYNC_SYMS[7:0];

  logic [2:0] r_bit_cnt;
  logic [7:0] r_sym;
  logic [7:0] r_sync_cnt;
  logic       r_state;
  logic       r_out;
  logic       r_active;
  logic       r_com_sent;

  logic       w_load;
  logic       w_sync_phase;
  logic       w_sel_com;
  logic [7:0] w_next_sym;

  always_comb begin
    w_load       = (r_bit_cnt == 3'd0);
    w_sync_phase = (r_state == ST_SYNC) && (r_sync_cnt < SYNC_N);
    // COM is forced during training, otherwise inserted when no valid word is offered
    w_sel_com    = w_sync_phase || !in[0];
    w_next_sym   = w_sel_com ? COM : in[8:1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit_cnt  <= '0;
      r_sym      <= '0;
      r_sync_cnt <= '0;
      r_state    <= ST_SYNC;
      r_out      <= 1'b0;
      r_active   <= 1'b0;
      r_com_sent <= 1'b0;
    end else begin
      r_bit_cnt  <= r_bit_cnt + 3'd1;
      r_com_sent <= 1'b0;
      if (w_load) begin
        r_sym      <= w_next_sym;
        r_out      <= w_next_sym[7];
        r_com_sent <= w_sel_com;
        if (w_sync_phase) begin
          r_sync_cnt <= r_sync_cnt + 8'd1;
        end else if (r_state == ST_SYNC) begin
          r_state  <= ST_DATA;
          r_active <= 1'b1;
        end
      end else begin
        r_out <= r_sym[3'd7 - r_bit_cnt];
      end
    end
  end

  assign word_req = w_load;
  assign out      = r_out;
  assign active   = r_active;
  assign com_sent = r_com_sent;

endmodule

// File: tb/tb_par2serial_tx.sv
// Scoreboarded bench for par2serial_tx: a symbol-level reference model queues the
// expected per-cycle outputs, a monitor compares them against the DUT.
module tb_par2serial_tx;

  localparam int unsigned SYNC = 4;
  localparam logic [7:0]  COMS = 8'hBC;

  logic       clk;
  logic       reset;
  logic [8:0] in;
  logic       word_req;
  logic       out;
  logic       active;
  logic       com_sent;

  par2serial_tx #(.SYNC_SYMS(SYNC), .COM(COMS)) dut (
    .clk(clk), .reset(reset), .in(in),
    .word_req(word_req), .out(out), .active(active), .com_sent(com_sent)
  );

  typedef struct packed {
    logic o;
    logic act;
    logic com;
    logic req;
  } exp_t;

  exp_t sbq[$];
  logic bitq[$];
  int   m_cyc;
  int   m_loads;
  logic m_act;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one entry per edge describing the outputs after that edge.
  always @(posedge clk) begin
    exp_t e;
    logic [7:0] s;
    logic c;
    if (!reset) begin
      m_cyc   = 0;
      m_loads = 0;
      m_act   = 1'b0;
      bitq.delete();
      e = '{o: 1'b0, act: 1'b0, com: 1'b0, req: 1'b1};
    end else begin
      c = 1'b0;
      if (m_cyc % 8 == 0) begin
        if (m_loads < SYNC) begin
          s = COMS; c = 1'b1;
        end else begin
          m_act = 1'b1;
          if (in[0]) s = in[8:1];
          else begin s = COMS; c = 1'b1; end
        end
        m_loads++;
        for (int i = 7; i >= 0; i--) bitq.push_back(s[i]);
      end
      m_cyc++;
      e.o   = bitq.pop_front();
      e.act = m_act;
      e.com = c;
      e.req = (m_cyc % 8 == 0);
    end
    sbq.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got empty queue, need one entry at t=%0t", $time);
    end else begin
      e = sbq.pop_front();
      n_checks += 3;
      if (out !== e.o) begin
        n_fail++;
        $display("FAIL out: got %b need %b at t=%0t", out, e.o, $time);
      end
      if (active !== e.act) begin
        n_fail++;
        $display("FAIL active: got %b need %b at t=%0t", active, e.act, $time);
      end
      if (com_sent !== e.com) begin
        n_fail++;
        $display("FAIL com_sent: got %b need %b at t=%0t", com_sent, e.com, $time);
      end
      if (word_req !== e.req) begin
        n_fail++;
        $display("FAIL word_req: got %b need %b at t=%0t", word_req, e.req, $time);
      end
    end
  end

  // Drives w at the next load edge; other cycles carry random values that must be ignored.
  task automatic send(input logic [8:0] w);
    @(negedge clk);
    while (m_cyc % 8 != 0) begin
      in = 9'($urandom);
      @(negedge clk);
    end
    in = w;
    @(negedge clk);
    in = 9'($urandom);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    in       = 9'h14B;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8 * 6) @(negedge clk);

    repeat (3) send(9'h1FE);
    repeat (2) send(9'h179);
    send(9'h003);
    send(9'h101);
    send(9'h1FF);
    repeat (20) send(9'($urandom));

    @(negedge clk);
    while (m_cyc % 8 != 4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    in    = 9'h14B;
    repeat (8 * 5 + 3) @(negedge clk);
    repeat (10) send(9'($urandom));
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
